// File: rtl/mes_amp_sin_mc_if.sv
// Bus bundle for the multi-channel quadrature sine-amplitude meter.
// The peak-hold signals exist only when MES_AMP_PEAK_HOLD_EN is defined.
interface mes_amp_sin_mc_if #(
    parameter int unsigned M   = 12,
    parameter int unsigned CH  = 4,
    parameter int unsigned CBW = 8
);
    logic                    ce;
    logic [CBW-1:0]          NT;
    logic [CH*(M+1)-1:0]     SIN;
    logic                    we;
    logic                    ce_tact;
    logic                    ce_S1;
    logic                    ce_S2;
    logic                    busy;
    logic                    amp_vld;
    logic [2:0]              amp_ch;
    logic [M:0]              AMP_CH;
    logic [CH*(M+1)-1:0]     AMP_ALL;
    logic                    ovr;
`ifdef MES_AMP_PEAK_HOLD_EN
    logic                    pk_clr;
    logic [CH*(M+1)-1:0]     PEAK_ALL;

    modport master (
        output ce, NT, SIN, we, pk_clr,
        input  ce_tact, ce_S1, ce_S2, busy, amp_vld, amp_ch, AMP_CH, AMP_ALL, ovr, PEAK_ALL
    );
    modport slave (
        input  ce, NT, SIN, we, pk_clr,
        output ce_tact, ce_S1, ce_S2, busy, amp_vld, amp_ch, AMP_CH, AMP_ALL, ovr, PEAK_ALL
    );
`else
    modport master (
        output ce, NT, SIN, we,
        input  ce_tact, ce_S1, ce_S2, busy, amp_vld, amp_ch, AMP_CH, AMP_ALL, ovr
    );
    modport slave (
        input  ce, NT, SIN, we,
        output ce_tact, ce_S1, ce_S2, busy, amp_vld, amp_ch, AMP_CH, AMP_ALL, ovr
    );
`endif
endinterface

// File: rtl/mes_amp_sin_mc.sv
// Multi-channel quadrature sine-amplitude meter with one shared bit-serial square-root engine.
// Optional peak hold per channel is built when MES_AMP_PEAK_HOLD_EN is defined.
module mes_amp_sin_mc #(
    parameter int unsigned M   = 12,
    parameter int unsigned CH  = 4,
    parameter int unsigned ND  = 2,
    parameter int unsigned NS  = 2**M,
    parameter int unsigned CBW = 8
) (
    input logic             clk,
    input logic             rst_n,
    mes_amp_sin_mc_if.slave bus
);
    localparam int unsigned SW = M + 1;
    localparam int unsigned QW = 2 * M + 1;
    localparam int unsigned RW = M + 6;
    localparam int unsigned IW = $clog2(M + 2);

    typedef enum logic [1:0] {StIdle, StLoad, StIter, StStore} state_e;

    logic [CBW-1:0]        cb_tact_q;
    logic                  twe_q;
    logic                  sq_ld_q;
    logic                  ce_tact, ce_s1, ce_s2;
    logic signed [SW-1:0]  s1_q [CH];
    logic signed [SW-1:0]  s2_q [CH];
    logic [M-1:0]          m1 [CH];
    logic [M-1:0]          m2 [CH];
    logic [2*M-1:0]        p1 [CH];
    logic [2*M-1:0]        p2 [CH];
    logic [QW-1:0]         sq [CH];
    logic [QW-1:0]         q_q [CH];

    state_e                state_q, state_d;
    logic [2:0]            ch_q, ch_d;
    logic [IW-1:0]         it_q, it_d;
    logic [QW:0]           rad_q, rad_d;
    logic [RW-1:0]         rem_q, rem_d, rem_sh, rem_nx;
    logic [M:0]            root_q, root_d;
    logic [QW-1:0]         q_sel;
    logic                  start, store, ovr_set;

    logic [SW-1:0]         amp_q [CH];
    logic [SW-1:0]         amp_cur_q;
    logic [2:0]            amp_ch_q;
    logic                  amp_vld_q;
    logic                  ovr_q;
    logic [CH*SW-1:0]      amp_all;

    // Magnitude of a two's-complement sample; -2^M saturates to 2^M-1.
    function automatic logic [M-1:0] mag_f(input logic signed [SW-1:0] s);
        logic [SW-1:0] n;
        n = -s;
        if (!s[M]) return s[M-1:0];
        return n[M] ? {M{1'b1}} : n[M-1:0];
    endfunction

    assign ce_tact     = (cb_tact_q == bus.NT);
    assign ce_s1       = (cb_tact_q == CBW'(ND));
    assign ce_s2       = (cb_tact_q == CBW'(ND) + (bus.NT >> 2));
    assign bus.ce_tact = ce_tact;
    assign bus.ce_S1   = ce_s1;
    assign bus.ce_S2   = ce_s2;

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            m1[k] = mag_f(s1_q[k]);
            m2[k] = mag_f(s2_q[k]);
            p1[k] = m1[k] * m1[k];
            p2[k] = m2[k] * m2[k];
            sq[k] = {1'b0, p1[k]} + {1'b0, p2[k]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cb_tact_q <= '0;
            twe_q     <= 1'b0;
            sq_ld_q   <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                s1_q[k] <= '0;
                s2_q[k] <= '0;
                q_q[k]  <= '0;
            end
        end else if (bus.ce) begin
            cb_tact_q <= ce_tact ? CBW'(1) : cb_tact_q + CBW'(1);
            if (ce_tact) twe_q <= bus.we;
            sq_ld_q <= ce_s2;
            for (int k = 0; k < CH; k++) begin
                if (ce_s1) s1_q[k] <= bus.SIN[k*SW +: SW] - SW'(NS);
                if (ce_s2) s2_q[k] <= bus.SIN[k*SW +: SW] - SW'(NS);
                if (sq_ld_q) q_q[k] <= sq[k];
            end
        end
    end

    assign start = sq_ld_q && twe_q;

    // Non-restoring root: signed remainder picks add or subtract for the next digit.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        it_d    = it_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        store   = 1'b0;
        ovr_set = 1'b0;
        q_sel   = '0;
        for (int k = 0; k < CH; k++) begin
            if (ch_q == 3'(k)) q_sel = q_q[k];
        end
        rem_sh = RW'({rem_q, rad_q[QW:QW-1]});
        rem_nx = rem_q[RW-1] ? rem_sh + RW'({root_q, 2'b11}) : rem_sh - RW'({root_q, 2'b01});
        unique case (state_q)
            StIdle: ch_d = '0;
            StLoad: begin
                rad_d   = {1'b0, q_sel};
                rem_d   = '0;
                root_d  = '0;
                it_d    = '0;
                state_d = StIter;
            end
            StIter: begin
                rem_d  = rem_nx;
                root_d = {root_q[M-1:0], ~rem_nx[RW-1]};
                rad_d  = rad_q << 2;
                it_d   = it_q + IW'(1);
                if (it_q == IW'(M)) state_d = StStore;
            end
            StStore: begin
                store = 1'b1;
                if (ch_q == 3'(CH - 1)) begin
                    state_d = StIdle;
                end else begin
                    ch_d    = ch_q + 3'd1;
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new square-sum set always wins; an unfinished pass is abandoned.
        if (start) begin
            ovr_set = (state_q != StIdle);
            store   = 1'b0;
            ch_d    = '0;
            state_d = StLoad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            it_q      <= '0;
            rad_q     <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            amp_cur_q <= '0;
            amp_ch_q  <= '0;
            amp_vld_q <= 1'b0;
            ovr_q     <= 1'b0;
            for (int k = 0; k < CH; k++) amp_q[k] <= '0;
        end else if (bus.ce) begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            it_q      <= it_d;
            rad_q     <= rad_d;
            rem_q     <= rem_d;
            root_q    <= root_d;
            amp_vld_q <= store;
            if (ovr_set) ovr_q <= 1'b1;
            if (store) begin
                amp_ch_q  <= ch_q;
                amp_cur_q <= root_q;
                for (int k = 0; k < CH; k++) begin
                    if (ch_q == 3'(k)) amp_q[k] <= root_q;
                end
            end
        end
    end

    always_comb begin
        amp_all = '0;
        for (int k = 0; k < CH; k++) amp_all[k*SW +: SW] = amp_q[k];
    end

    assign bus.AMP_ALL = amp_all;
    assign bus.AMP_CH  = amp_cur_q;
    assign bus.amp_ch  = amp_ch_q;
    assign bus.amp_vld = amp_vld_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.ovr     = ovr_q;

`ifdef MES_AMP_PEAK_HOLD_EN
    logic [SW-1:0]    pk_q [CH];
    logic [CH*SW-1:0] peak_all;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH; k++) pk_q[k] <= '0;
        end else if (bus.ce) begin
            for (int k = 0; k < CH; k++) begin
                if (store && ch_q == 3'(k) && (bus.pk_clr || root_q > pk_q[k])) begin
                    pk_q[k] <= root_q;
                end else if (bus.pk_clr) begin
                    pk_q[k] <= '0;
                end
            end
        end
    end

    always_comb begin
        peak_all = '0;
        for (int k = 0; k < CH; k++) peak_all[k*SW +: SW] = pk_q[k];
    end

    assign bus.PEAK_ALL = peak_all;
`endif
endmodule

// File: tb/tb_mes_amp_sin_mc.sv
// Randomised bench for mes_amp_sin_mc against a tick-counting reference model.
// Peak-hold checks are compiled in when MES_AMP_PEAK_HOLD_EN is defined.
module tb_mes_amp_sin_mc;
    localparam int unsigned M   = 12;
    localparam int unsigned CH  = 4;
    localparam int unsigned ND  = 2;
    localparam int unsigned CBW = 8;
    localparam int unsigned SW  = M + 1;
    localparam int          NS  = 4096;
    localparam int          LAT = M + 3;

    typedef struct {
        int tick;
        int ch;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mes_amp_sin_mc_if #(.M(M), .CH(CH), .CBW(CBW)) bus ();

    mes_amp_sin_mc #(.M(M), .CH(CH), .ND(ND), .NS(NS), .CBW(CBW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int  nt;
    int  n;
    bit  pend, twe, exp_vld, model_on, use_ce_rand, pk_rand, pk_now;
    int  exp_ch, exp_cur;
    int  s1m [CH];
    int  s2m [CH];
    int  exp_amp [CH];
    int  exp_pk [CH];
    ev_t evq [$];
    logic [SW-1:0] st1 [CH];
    logic [SW-1:0] st2 [CH];
    bit  st_we;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tick %0d)", tag, got, exp, n);
        end
    endtask

    function automatic int mag_of(input int s);
        if (s >= 0) return s;
        if (s == -NS) return NS - 1;
        return -s;
    endfunction

    function automatic int isqrt(input longint q);
        longint r = 0;
        while ((r + 1) * (r + 1) <= q) r++;
        return int'(r);
    endfunction

    // Tact position in force before ce tick t (t counts from 1 after reset).
    function automatic int pos_of(input int t);
        if (t <= 1) return 0;
        return ((t - 2) % nt) + 1;
    endfunction

    task automatic model_tick();
        int p;
        int v;
        ev_t e;
        n++;
        p = pos_of(n);
        if (pend) begin
            pend = 1'b0;
            if (twe) begin
                for (int k = 0; k < CH; k++) begin
                    v = isqrt(longint'(mag_of(s1m[k])) * mag_of(s1m[k]) +
                              longint'(mag_of(s2m[k])) * mag_of(s2m[k]));
                    evq.push_back('{tick: n + (k + 1) * LAT, ch: k, val: v});
                end
            end
        end
        if (p == ND) for (int k = 0; k < CH; k++) s1m[k] = int'(bus.SIN[k*SW +: SW]) - NS;
        if (p == ND + nt / 4) begin
            for (int k = 0; k < CH; k++) s2m[k] = int'(bus.SIN[k*SW +: SW]) - NS;
            pend = 1'b1;
        end
        if (p == nt) twe = st_we;
        if (pk_now) for (int k = 0; k < CH; k++) exp_pk[k] = 0;
        exp_vld = 1'b0;
        if (evq.size() != 0 && evq[0].tick == n) begin
            e = evq.pop_front();
            exp_vld = 1'b1;
            exp_ch  = e.ch;
            exp_cur = e.val;
            exp_amp[e.ch] = e.val;
            if (e.val > exp_pk[e.ch]) exp_pk[e.ch] = e.val;
        end
    endtask

    task automatic clock_once();
        bit ce_v;
        int p;
        ce_v = use_ce_rand ? ($urandom_range(3) != 0) : 1'b1;
        pk_now = pk_rand && ($urandom_range(15) == 0);
        p = pos_of(n + 1);
        for (int k = 0; k < CH; k++) bus.SIN[k*SW +: SW] = (p <= ND) ? st1[k] : st2[k];
        bus.we = st_we;
        bus.ce = ce_v;
`ifdef MES_AMP_PEAK_HOLD_EN
        bus.pk_clr = pk_now;
`endif
        @(posedge clk);
        #1;
        if (ce_v) model_tick();
        if (model_on) begin
            chk("amp_vld", bus.amp_vld, exp_vld);
            if (exp_vld) begin
                chk("amp_ch", bus.amp_ch, exp_ch);
                chk("AMP_CH", bus.AMP_CH, exp_cur);
            end
            chk("busy", bus.busy, evq.size() != 0);
            chk("ovr", bus.ovr, 0);
            chk("ce_tact", bus.ce_tact, pos_of(n + 1) == nt);
            chk("ce_S1", bus.ce_S1, pos_of(n + 1) == ND);
            chk("ce_S2", bus.ce_S2, pos_of(n + 1) == ND + nt / 4);
            for (int k = 0; k < CH; k++) begin
                chk("AMP_ALL", bus.AMP_ALL[k*SW +: SW], exp_amp[k]);
`ifdef MES_AMP_PEAK_HOLD_EN
                chk("PEAK_ALL", bus.PEAK_ALL[k*SW +: SW], exp_pk[k]);
`endif
            end
        end
    endtask

    task automatic run_ticks(input int cnt);
        for (int i = 0; i < cnt; i++) clock_once();
    endtask

    task automatic do_reset(input int new_nt);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_AMP_ALL", bus.AMP_ALL, 0);
        chk("rst_AMP_CH", bus.AMP_CH, 0);
        chk("rst_amp_ch", bus.amp_ch, 0);
        chk("rst_amp_vld", bus.amp_vld, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovr", bus.ovr, 0);
`ifdef MES_AMP_PEAK_HOLD_EN
        chk("rst_PEAK_ALL", bus.PEAK_ALL, 0);
`endif
        nt = new_nt;
        bus.NT = CBW'(new_nt);
        n = 0;
        pend = 1'b0;
        twe = 1'b0;
        exp_vld = 1'b0;
        evq.delete();
        for (int k = 0; k < CH; k++) begin
            s1m[k] = 0;
            s2m[k] = 0;
            exp_amp[k] = 0;
            exp_pk[k] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_mid();
        for (int k = 0; k < CH; k++) begin
            st1[k] = SW'(NS);
            st2[k] = SW'(NS);
        end
    endtask

    initial begin
        bus.ce = 1'b0;
        bus.we = 1'b0;
        bus.NT = CBW'(64);
        bus.SIN = '0;
`ifdef MES_AMP_PEAK_HOLD_EN
        bus.pk_clr = 1'b0;
`endif
        model_on = 1'b1;
        use_ce_rand = 1'b0;
        pk_rand = 1'b0;
        pk_now = 1'b0;

        // Directed periods, NT=64.
        do_reset(64);
        set_mid();
        st_we = 1'b1;
        run_ticks(64);
        st1[0] = SW'(NS + 3000);
        st2[0] = SW'(NS + 4000);
        st1[1] = '0;
        st2[1] = '0;
        run_ticks(64);
        st1[0] = SW'(NS - 300);
        st2[0] = SW'(NS + 400);
        st1[1] = SW'(NS - 1);
        st2[1] = SW'(NS);
        st1[2] = SW'(NS + 3000);
        st2[2] = SW'(NS - 4000);
        st_we = 1'b0;
        run_ticks(64);
        chk("full_quad", bus.AMP_ALL[0*SW +: SW], 5000);
        chk("saturated", bus.AMP_ALL[1*SW +: SW], 5791);
        chk("mid_ch2", bus.AMP_ALL[2*SW +: SW], 0);
        chk("mid_ch3", bus.AMP_ALL[3*SW +: SW], 0);
        st_we = 1'b1;
        run_ticks(64);
        set_mid();
        st_we = 1'b0;
        run_ticks(64);
        chk("neg_quad", bus.AMP_ALL[0*SW +: SW], 500);
        chk("minus_one", bus.AMP_ALL[1*SW +: SW], 1);
        chk("quad4", bus.AMP_ALL[2*SW +: SW], 5000);
        chk("mid_ch3b", bus.AMP_ALL[3*SW +: SW], 0);
`ifdef MES_AMP_PEAK_HOLD_EN
        chk("peak_ch0", bus.PEAK_ALL[0*SW +: SW], 5000);
`endif

        // Random samples, random we, ce gaps and peak clears, NT=100.
        do_reset(100);
        use_ce_rand = 1'b1;
        pk_rand = 1'b1;
        for (int per = 0; per < 12; per++) begin
            for (int k = 0; k < CH; k++) begin
                st1[k] = SW'($urandom_range(2 * NS - 1));
                st2[k] = SW'($urandom_range(2 * NS - 1));
                if ($urandom_range(5) == 0) st1[k] = '0;
                if ($urandom_range(5) == 0) st2[k] = SW'(2 * NS - 1);
            end
            st_we = ($urandom_range(3) != 0);
            run_ticks(100);
        end
        use_ce_rand = 1'b0;
        pk_rand = 1'b0;

        // Overrun with NT=16, then asynchronous reset mid-pass.
        do_reset(16);
        model_on = 1'b0;
        for (int k = 0; k < CH; k++) begin
            st1[k] = SW'($urandom_range(2 * NS - 1));
            st2[k] = SW'($urandom_range(2 * NS - 1));
        end
        st_we = 1'b1;
        run_ticks(32);
        chk("ovr_single_start", bus.ovr, 0);
        run_ticks(48);
        chk("ovr_set", bus.ovr, 1);
        chk("ovr_busy", bus.busy, 1);
        chk("ovr_noX", $isunknown({bus.AMP_ALL, bus.AMP_CH, bus.amp_ch, bus.amp_vld}), 0);
        do_reset(64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
